// File: rtl/mod12_seek_ctrl.sv
// mod12_seek_ctrl: round-robin seek controller steering a mod-MOD up/down counter (load/data_in/upd) to requested targets, with shadow sync check
module mod12_seek_ctrl #(
  parameter int MOD = 12,
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [1:0]   req,
  input  logic [W-1:0] target0,
  input  logic [W-1:0] target1,
  output logic [1:0]   gnt,
  output logic         busy,
  output logic         done,
  output logic         done_id,
  output logic         bad_tgt,
  output logic         load,
  output logic [W-1:0] data_in,
  output logic         upd,
  input  logic [W-1:0] count,
  output logic         sync_err
);
  typedef enum logic [1:0] {IDLE, DEC, SEEK, DONE} state_t;
  localparam logic [W:0] M = (W+1)'(MOD);
  localparam logic [W-1:0] TOP = W'(MOD - 1);
  state_t state, nxt;
  logic last, id, win, bad_in;
  logic [W-1:0] tgt, sh, sh_nx, steps, ts;
  logic [W:0] tx, px, du, dd;
  always_comb begin
    win = req[~last] ? ~last : last;
    ts = win ? target1 : target0;
    bad_in = {1'b0, ts} >= M;
    tx = {1'b0, tgt};
    px = {1'b0, sh};
    du = tx >= px ? tx - px : tx + M - px;
    dd = px >= tx ? px - tx : px + M - tx;
    sh_nx = load ? data_in : upd ? (sh == TOP ? '0 : sh + 1'b1) : (sh == '0 ? TOP : sh - 1'b1);
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE: nxt = (req != 2'b00 && !bad_in) ? DEC : IDLE;
      DEC:  nxt = du == '0 ? DONE : SEEK;
      SEEK: nxt = steps == W'(1) ? DONE : SEEK;
      DONE: nxt = IDLE;
    endcase
  end
  always_comb begin
    busy = state != IDLE;
    done = state == DONE;
    done_id = id;
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      last <= 1'b1;
      id <= 1'b0;
      tgt <= '0;
      sh <= '0;
      steps <= '0;
      load <= 1'b1;
      data_in <= '0;
      upd <= 1'b0;
      gnt <= 2'b00;
      bad_tgt <= 1'b0;
      sync_err <= 1'b0;
    end else begin
      sh <= sh_nx;
      if (count != sh) sync_err <= 1'b1;
      gnt <= 2'b00;
      bad_tgt <= 1'b0;
      if (state == IDLE && req != 2'b00) begin
        last <= win;
        id <= win;
        tgt <= ts;
        gnt <= {win, ~win};
        bad_tgt <= bad_in;
      end
      if (state == DEC && du != '0) begin
        load <= 1'b0;
        upd <= du <= dd;
        steps <= W'(du <= dd ? du : dd);
      end
      if (state == SEEK) begin
        steps <= steps - 1'b1;
        if (steps == W'(1)) begin
          load <= 1'b1;
          data_in <= tgt;
        end
      end
    end
endmodule

// File: tb/tb_mod12_seek_ctrl.sv
// tb_mod12_seek_ctrl: table-driven scoreboard bench for mod12_seek_ctrl with a behavioural mod-12 counter
module tb_mod12_seek_ctrl;
  logic clock = 1'b0, reset = 1'b1;
  logic [1:0] req = 2'b00;
  logic [3:0] target0 = 4'd0, target1 = 4'd0;
  logic [1:0] gnt;
  logic busy, done, done_id, bad_tgt, load, upd, sync_err;
  logic [3:0] data_in, count, cnt, fval = 4'd0;
  logic fen = 1'b0, mon_off = 1'b0;
  int errors = 0, checks = 0;
  int pos = 0;
  typedef struct {
    logic [1:0] g;
    int t;
    logic up;
    int steps;
    logic bad;
  } exp_t;
  typedef struct {
    logic [1:0] r;
    logic [3:0] t;
    logic [1:0] g;
    logic up;
    int steps;
    logic bad;
  } vec_t;
  exp_t q[$];
  vec_t tbl[7];
  int lowc = 0;
  logic seen_up = 1'b0, up_stable = 1'b1;

  always #5 clock = ~clock;

  mod12_seek_ctrl #(.MOD(12), .W(4)) dut (
    .clock(clock), .reset(reset), .req(req), .target0(target0), .target1(target1),
    .gnt(gnt), .busy(busy), .done(done), .done_id(done_id), .bad_tgt(bad_tgt),
    .load(load), .data_in(data_in), .upd(upd), .count(count), .sync_err(sync_err)
  );

  always @(posedge clock or posedge reset)
    if (reset) cnt <= 4'd0;
    else cnt <= load ? data_in : upd ? (cnt == 4'd11 ? 4'd0 : cnt + 4'd1) : (cnt == 4'd0 ? 4'd11 : cnt - 4'd1);
  assign count = fen ? fval : cnt;

  task automatic chk(input string n, input int a, input int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, a, e);
    end
  endtask

  task automatic expire(input string n);
    checks++;
    errors++;
    $display("FAIL %s: timed out", n);
  endtask

  function automatic exp_t mk(input logic [1:0] g, input int p, input int t);
    int u, d;
    u = (t - p + 12) % 12;
    d = (p - t + 12) % 12;
    mk.g = g;
    mk.t = t;
    mk.bad = 1'b0;
    mk.up = u <= d;
    mk.steps = (u <= d) ? u : d;
  endfunction

  always @(negedge clock) begin
    if (reset || mon_off) lowc = 0;
    else begin
      if (gnt != 2'b00) begin
        lowc = 0;
        up_stable = 1'b1;
        if (q.size() == 0) expire("stray_gnt");
        else chk("gnt", gnt, q[0].g);
      end
      if (!load) begin
        lowc++;
        if (lowc == 1) seen_up = upd;
        else if (upd != seen_up) up_stable = 1'b0;
      end
      if (bad_tgt) begin
        if (q.size() == 0) expire("stray_bad");
        else begin
          chk("bad_expected", 1, q[0].bad);
          chk("busy_on_bad", busy, 0);
          chk("done_on_bad", done, 0);
          void'(q.pop_front());
        end
      end
      if (done) begin
        if (q.size() == 0) expire("stray_done");
        else begin
          chk("done_not_bad", 0, q[0].bad);
          chk("done_id", done_id, q[0].g[1]);
          chk("count_at_done", count, q[0].t);
          chk("steps", lowc, q[0].steps);
          if (q[0].steps > 0) begin
            chk("upd_dir", seen_up, q[0].up);
            chk("upd_stable", up_stable, 1);
          end
          void'(q.pop_front());
        end
      end
    end
  end

  task automatic run(input logic [1:0] r, input logic [3:0] t, input exp_t e);
    bit ok;
    q.push_back(e);
    target0 = t;
    target1 = t;
    req = r;
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clock);
      #1;
      ok = gnt != 2'b00;
    end
    req = 2'b00;
    if (!ok) begin
      expire("wait_gnt");
      q.delete();
      return;
    end
    ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (q.size() == 0) ok = 1;
      else begin
        @(negedge clock);
        #1;
      end
    end
    if (!ok) begin
      expire("wait_done");
      q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    exp_t e;
    bit ok;
    tbl[0] = '{r: 2'b01, t: 4'd5,  g: 2'b01, up: 1'b1, steps: 5, bad: 1'b0};
    tbl[1] = '{r: 2'b01, t: 4'd1,  g: 2'b01, up: 1'b0, steps: 4, bad: 1'b0};
    tbl[2] = '{r: 2'b10, t: 4'd10, g: 2'b10, up: 1'b0, steps: 3, bad: 1'b0};
    tbl[3] = '{r: 2'b01, t: 4'd4,  g: 2'b01, up: 1'b1, steps: 6, bad: 1'b0};
    tbl[4] = '{r: 2'b01, t: 4'd13, g: 2'b01, up: 1'b0, steps: 0, bad: 1'b1};
    tbl[5] = '{r: 2'b10, t: 4'd4,  g: 2'b10, up: 1'b0, steps: 0, bad: 1'b0};
    tbl[6] = '{r: 2'b01, t: 4'd0,  g: 2'b01, up: 1'b0, steps: 4, bad: 1'b0};
    repeat (2) @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      #1;
      chk("idle_load", load, 1);
      chk("idle_data_in", data_in, 0);
      chk("idle_count", count, 0);
      chk("idle_busy", busy, 0);
      chk("idle_sync_err", sync_err, 0);
    end
    for (int i = 0; i < 7; i++) begin
      e.g = tbl[i].g;
      e.t = tbl[i].t;
      e.up = tbl[i].up;
      e.steps = tbl[i].steps;
      e.bad = tbl[i].bad;
      run(tbl[i].r, tbl[i].t, e);
      if (tbl[i].bad) begin
        repeat (3) begin
          @(negedge clock);
          #1;
          chk("bad_count_hold", count, pos);
          chk("bad_busy", busy, 0);
        end
      end else pos = tbl[i].t;
      if (i == 0) begin
        for (int k = 0; k < 10; k++) begin
          @(negedge clock);
          #1;
          chk("hold_count", count, 5);
        end
      end
    end
    target0 = 4'd3;
    target1 = 4'd9;
    q.push_back(mk(2'b10, pos, 9));
    q.push_back(mk(2'b01, 9, 3));
    q.push_back(mk(2'b10, 3, 9));
    q.push_back(mk(2'b01, 9, 3));
    req = 2'b11;
    ok = 0;
    for (int i = 0; i < 120 && !ok; i++) begin
      @(negedge clock);
      #1;
      ok = q.size() == 0;
    end
    req = 2'b00;
    if (!ok) begin
      expire("alternate");
      q.delete();
    end
    pos = 3;
    run(2'b01, 4'd0, mk(2'b01, pos, 0));
    pos = 0;
    mon_off = 1'b1;
    target0 = 4'd6;
    req = 2'b01;
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clock);
      #1;
      ok = gnt == 2'b01;
    end
    req = 2'b00;
    if (!ok) expire("reset_gnt");
    repeat (4) @(negedge clock);
    #1;
    chk("mid_seek_count", count, 3);
    chk("mid_seek_load", load, 0);
    reset = 1'b1;
    #1;
    chk("rst_load", load, 1);
    chk("rst_data_in", data_in, 0);
    chk("rst_upd", upd, 0);
    chk("rst_busy", busy, 0);
    chk("rst_count", count, 0);
    chk("rst_gnt", gnt, 0);
    @(negedge clock);
    reset = 1'b0;
    ok = 1;
    repeat (8) begin
      @(negedge clock);
      #1;
      if (done || busy) ok = 0;
    end
    chk("no_done_after_rst", ok, 1);
    mon_off = 1'b0;
    run(2'b01, 4'd2, mk(2'b01, 0, 2));
    @(negedge clock);
    #1;
    chk("sync_err_clean", sync_err, 0);
    fval = 4'd7;
    fen = 1'b1;
    @(negedge clock);
    #1;
    fen = 1'b0;
    chk("sync_err_set", sync_err, 1);
    repeat (5) @(negedge clock);
    #1;
    chk("sync_err_sticky", sync_err, 1);
    reset = 1'b1;
    #1;
    chk("sync_err_rst", sync_err, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mod12_seek_ctrl.md
Name: mod12_seek_ctrl

Overview:
Controller that sequences the mod-12 up/down counter on behalf of two requesters. Each requester asks for a target count value. The controller arbitrates round-robin, picks the shortest direction around the modulus, drives the counter's load/data_in/upd pins for exactly the required number of steps, then holds the counter at the target. A shadow model of the counter checks the returned count every cycle.

Parameters:
MOD, 12, counter modulus; legal targets are 0..MOD-1
W, 4, width of count, data_in and target fields

Ports:
clock  input  1  system clock; all state changes on posedge
reset  input  1  asynchronous, active-high; shared with the counter
req  input  2  request per requester; held high until gnt
target0  input  W  target for requester 0; sampled at grant
target1  input  W  target for requester 1; sampled at grant
gnt  output  2  one-hot, one-cycle grant pulse
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse when the counter reaches the target
done_id  output  1  requester index for done; valid with done
bad_tgt  output  1  one-cycle pulse when a granted target is >= MOD
load  output  1  counter load strobe (registered)
data_in  output  W  counter load value (registered)
upd  output  1  counter direction, 1=up, 0=down (registered)
count  input  W  counter output
sync_err  output  1  sticky; set when count != shadow

Behaviour:
- Counter contract, applied per posedge: load ? data_in : (upd ? (count+1)%MOD : (count+MOD-1)%MOD). Reset gives count=0.
- Reset values:
  - State IDLE; shadow=0; load=1; data_in=0; upd=0.
  - gnt=0, busy=0, done=0, done_id=0, bad_tgt=0, sync_err=0.
  - Round-robin pointer last=1, so requester 0 wins first.
- The shadow register applies the counter contract to the controller's own registered load/data_in/upd at every posedge.
- sync_err: at each posedge out of reset, if count != shadow, sync_err<=1. It clears only on reset.
- IDLE:
  - load=1 and data_in=shadow, which holds the counter.
  - At a posedge with req!=0, the winner is the requester other than last if it is requesting, else the requesting one.
  - Update last, set gnt<=onehot(winner), latch tgt and id.
- Decode at grant, combinational from the latched/sampled target and shadow P:
  - If tgt>=MOD: bad_tgt<=1 and stay in IDLE. Outputs are unchanged and there is no done.
  - Otherwise du=(tgt-P+MOD)%MOD and dd=(P-tgt+MOD)%MOD.
  - If du==0: go to DONE; load stays 1.
  - Else if du<=dd: upd<=1, steps<=du. Otherwise upd<=0, steps<=dd. A tie at 6 goes up.
  - In both move cases: load<=0, state<=SEEK.
- SEEK:
  - load=0 and upd is held; steps decrements at each posedge.
  - At the posedge where steps==1: load<=1, data_in<=tgt, state<=DONE. At that edge the shadow takes its final step and equals tgt.
  - Cycles with load=0 = steps exactly (1..6).
- DONE: one cycle with done=1 and done_id=id, then IDLE. The hold continues (data_in=tgt=shadow).
- req is ignored while busy. The requester keeps req high after gnt only if it wants a new request.
- Latency:
  - gnt is visible 1 cycle after req is sampled.
  - done is visible steps+1 cycles after gnt; with steps==0, the cycle after gnt.
- Reset mid-SEEK: everything returns to reset values immediately (asynchronous). No done is issued. The counter and shadow both go to 0.

Test Plan:
- Reset, then idle 5 cycles -> load=1, data_in=0, count=0, busy=0, sync_err=0 throughout.
- req=01, target0=5 from 0 -> gnt=01; upd=1 for 5 cycles; count 1,2,3,4,5; done, done_id=0; count holds at 5 for 10 cycles.
- Wrap and direction:
  - From 1, target1=10 -> upd=0; 3 steps 0,11,10; done_id=1.
  - Then target0=4 (du=6=dd) -> upd=1; 6 steps 11,0,1,2,3,4.
- req=11 held continuously, each request re-armed -> grants alternate 01,10,01,10. Each done_id matches its grant.
- Bad target and same-position target:
  - target0=13 -> gnt=01 and bad_tgt pulse; no done; count unchanged; busy stays 0.
  - target0 equal to the current count -> done the cycle after gnt with zero steps.
- Reset and sync checks:
  - Assert reset during SEEK from 0 toward 6 at step 3 -> outputs return to reset values; count=0; no done.
  - Force count=7 for one cycle while the shadow is 2 -> sync_err=1 and stays set until reset.
